// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem reads and
// buffers returned words with their PCs. Define IFQ_PERF_EN for perf counters.
`timescale 1ns/1ps
module ifetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] load_pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          instr_valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
`ifdef IFQ_PERF_EN
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_flushed,
`endif
    input  logic          instr_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   LIMIT   = DEPTH[CW:0];
    localparam logic [CW-1:0] FULL    = DEPTH[CW-1:0];
    localparam logic [AW-1:0] PC_STEP = AW'(4);

    typedef enum logic {S_BOOT, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] data_q [DEPTH];
    logic [AW-1:0] pc_q [DEPTH];

    logic          run, credit_ok, accept, push, pop, drop;
    logic [AW-1:0] boot_pc, target_pc;
    logic          unused_pc_bits;

    assign boot_pc        = {load_pc[AW-1:2], 2'b00};
    assign target_pc      = {redirect_pc[AW-1:2], 2'b00};
    assign unused_pc_bits = ^{load_pc[1:0], redirect_pc[1:0]};

    // Every in-flight read owns a FIFO slot, so a response can never find the FIFO full.
    always_comb begin
        run         = (state_q == S_RUN);
        credit_ok   = ({1'b0, outstanding_q} + {1'b0, count_q}) < LIMIT;
        imem_req    = run && !redirect && credit_ok;
        imem_addr   = fetch_pc_q;
        accept      = imem_req && imem_ready;
        instr_valid = (count_q != '0);
        instr       = data_q[rd_ptr_q];
        instr_pc    = pc_q[rd_ptr_q];
        pop         = instr_valid && instr_ready;
        drop        = run && !redirect && imem_rvalid && (discard_q != '0);
        push        = run && !redirect && imem_rvalid && (discard_q == '0);
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        case (state_q)
            S_BOOT: begin
                fetch_pc_d = boot_pc;
                rsp_pc_d   = boot_pc;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (redirect) begin
                    // Reads still in flight (minus the one landing now) come back stale.
                    fetch_pc_d    = target_pc;
                    rsp_pc_d      = target_pc;
                    count_d       = '0;
                    wr_ptr_d      = '0;
                    rd_ptr_d      = '0;
                    outstanding_d = outstanding_q - CW'(imem_rvalid);
                    discard_d     = outstanding_q - CW'(imem_rvalid);
                end else begin
                    if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
                    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rvalid);
                    if (drop) discard_d = discard_q - CW'(1);
                    if (push) begin
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        rsp_pc_d = rsp_pc_q + PC_STEP;
                    end
                    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
                    count_d = count_q + CW'(push) - CW'(pop);
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_BOOT;
            fetch_pc_q    <= '0;
            rsp_pc_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= imem_rdata;
            pc_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (reset) push |-> (count_q != FULL));

`ifdef IFQ_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic [CW:0] flush_inc;
    logic [32:0] fetched_sum, flushed_sum;

    // Flushed = entries lost from the FIFO plus responses thrown away, counted as they land.
    always_comb begin
        flush_inc = '0;
        if (run && redirect)
            flush_inc = {1'b0, count_q} - (CW+1)'(pop) + (CW+1)'(imem_rvalid);
        else if (drop)
            flush_inc = (CW+1)'(1);
        fetched_sum    = {1'b0, perf_fetched_q} + 33'(pop);
        flushed_sum    = {1'b0, perf_flushed_q} + 33'(flush_inc);
        perf_fetched_d = fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
        perf_flushed_d = flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: in-order memory model plus an instruction-stream reference
// (each delivered word must be the next PC of the current boot/redirect stream).
`timescale 1ns/1ps
module tb_ifetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] load_pc = '0, redirect_pc = '0, imem_rdata = '0;
    logic        imem_ready = 1'b0, imem_rvalid = 1'b0, redirect = 1'b0, instr_ready = 1'b0;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc;
`ifdef IFQ_PERF_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    ifetch_queue #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .load_pc(load_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
`ifdef IFQ_PERF_EN
        .perf_fetched(perf_fetched), .perf_flushed(perf_flushed),
`endif
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    int cyc = 0, mem_lat = 1;
    bit rand_ready = 0, rv_gaps = 0, mon_en = 0;
    logic [31:0] exp_pc = '0, exp_fetch = '0;
    int acc_cnt = 0, pop_cnt = 0;
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    logic cap_acc = 1'b0, cap_rv = 1'b0;
    logic [31:0] cap_addr = '0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    // In-order memory: accepted at edge N, data valid from cycle N+mem_lat onward.
    always begin
        @(posedge clk); #1;
        cyc++;
        if (reset) begin
            mq.delete();
            imem_rvalid = 1'b0;
        end else begin
            if (cap_rv) void'(mq.pop_front());
            if (cap_acc) mq.push_back('{cap_addr, cyc + mem_lat});
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (mq.size() > 0 && mq[0].due <= cyc && (!rv_gaps || $urandom_range(0, 3) != 0)) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memfn(mq[0].addr);
            end
            if (rand_ready) imem_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Stream monitor: sampled mid-cycle, i.e. the values the next rising edge will see.
    always @(negedge clk) begin
        cap_acc = 1'b0;
        cap_rv  = 1'b0;
        if (!reset) begin
            cap_acc  = imem_req && imem_ready;
            cap_addr = imem_addr;
            cap_rv   = imem_rvalid;
            if (mon_en) begin
                if (cap_acc) begin
                    total++;
                    if (imem_addr !== exp_fetch) $display("FAIL fetch_addr: got %h expected %h", imem_addr, exp_fetch);
                    else passed++;
                    total++;
                    if (mq.size() >= DEPTH) $display("FAIL credit: got %0d reads in flight at accept, required < %0d", mq.size(), DEPTH);
                    else passed++;
                    acc_log.push_back(imem_addr);
                    acc_cnt++;
                    exp_fetch = exp_fetch + 32'd4;
                end
                if (instr_valid && instr_ready) begin
                    total++;
                    if (instr_pc !== exp_pc) $display("FAIL instr_pc: got %h expected %h", instr_pc, exp_pc);
                    else passed++;
                    total++;
                    if (instr !== memfn(exp_pc)) $display("FAIL instr_data: got %h expected %h", instr, memfn(exp_pc));
                    else passed++;
                    pop_log.push_back(instr_pc);
                    pop_cnt++;
                    exp_pc = exp_pc + 32'd4;
                end
                if (redirect) begin
                    total++;
                    if (imem_req !== 1'b0) $display("FAIL req_in_redirect: got %b expected 0", imem_req);
                    else passed++;
                    exp_pc    = {redirect_pc[31:2], 2'b00};
                    exp_fetch = exp_pc;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    // Leaves the DUT in BOOT at posedge+2 with reset released.
    task automatic do_boot(input logic [31:0] pc, input int lat);
        mon_en = 0; redirect = 1'b0; rand_ready = 0; rv_gaps = 0;
        @(posedge clk); #2;
        reset = 1'b1; imem_ready = 1'b1; mem_lat = lat;
        tick(1);
        load_pc = pc; reset = 1'b0;
        exp_pc = {pc[31:2], 2'b00}; exp_fetch = exp_pc;
        acc_cnt = 0; pop_cnt = 0; acc_log.delete(); pop_log.delete();
        mon_en = 1;
    endtask

    task automatic test_reset;
        tick(2);
        total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", imem_req); else passed++;
        total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h expected 0", imem_addr); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", instr_valid); else passed++;
        total++; if (instr !== 32'h0) $display("FAIL rst_instr: got %h expected 0", instr); else passed++;
        total++; if (instr_pc !== 32'h0) $display("FAIL rst_instr_pc: got %h expected 0", instr_pc); else passed++;
    endtask

    task automatic test_boot;
        do_boot(32'h0040_0020, 1);
        instr_ready = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) $display("FAIL boot_no_req: got %b expected 0", imem_req); else passed++;
        tick(1);
        total++; if (imem_req !== 1'b1) $display("FAIL boot_req: got %b expected 1", imem_req); else passed++;
        total++; if (imem_addr !== 32'h0040_0020) $display("FAIL boot_addr: got %h expected 00400020", imem_addr); else passed++;
        tick(1);
        total++; if (instr_valid !== 1'b0) $display("FAIL lat_n: got %b expected 0", instr_valid); else passed++;
        tick(1);
        total++; if (imem_rvalid !== 1'b1 || instr_valid !== 1'b0) $display("FAIL lat_n1: got rvalid=%b valid=%b expected 1/0", imem_rvalid, instr_valid); else passed++;
        tick(1);
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0040_0020) $display("FAIL lat_n2: got valid=%b pc=%h expected 1/00400020", instr_valid, instr_pc); else passed++;
        tick(10);
        total++;
        if (acc_log.size() < 3) $display("FAIL boot_seq: got %0d accepts expected >=3", acc_log.size());
        else if (acc_log[1] !== 32'h0040_0024 || acc_log[2] !== 32'h0040_0028) $display("FAIL boot_seq: got %h %h expected 00400024 00400028", acc_log[1], acc_log[2]);
        else passed++;
        total++; if (pop_cnt < 8) $display("FAIL boot_throughput: got %0d pops expected >=8", pop_cnt); else passed++;
    endtask

    task automatic test_backpressure;
        do_boot(32'h0040_0000, 1);
        instr_ready = 1'b0;
        tick(12);
        total++; if (acc_cnt != 4) $display("FAIL bp_accepts: got %0d expected 4", acc_cnt); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL bp_req: got %b expected 0", imem_req); else passed++;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0040_0000) $display("FAIL bp_head: got valid=%b pc=%h expected 1/00400000", instr_valid, instr_pc); else passed++;
        instr_ready = 1'b1;
        tick(4);
        total++; if (pop_cnt != 4) $display("FAIL bp_pops: got %0d expected 4", pop_cnt); else passed++;
        tick(4);
        total++;
        if (acc_log.size() < 5 || pop_log.size() < 5) $display("FAIL bp_resume: got %0d accepts %0d pops expected >=5 each", acc_log.size(), pop_log.size());
        else if (acc_log[4] !== 32'h0040_0010 || pop_log[4] !== 32'h0040_0010) $display("FAIL bp_resume: got acc %h pop %h expected 00400010", acc_log[4], pop_log[4]);
        else passed++;
    endtask

    task automatic test_redirect_outstanding;
        do_boot(32'h0040_0000, 3);
        instr_ready = 1'b0;
        tick(1);
        tick(1);
        imem_ready = 1'b0;
        tick(4);
        total++; if (instr_valid !== 1'b1) $display("FAIL ro_prefill: got %b expected 1", instr_valid); else passed++;
        imem_ready = 1'b1;
        tick(2);
        imem_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0040_0103;
        #1;
        total++; if (imem_req !== 1'b0) $display("FAIL ro_req: got %b expected 0", imem_req); else passed++;
        tick(1);
        redirect = 1'b0;
        total++; if (instr_valid !== 1'b0) $display("FAIL ro_flush: got %b expected 0", instr_valid); else passed++;
        pop_log.delete(); acc_log.delete();
        imem_ready = 1'b1; instr_ready = 1'b1;
        tick(20);
        total++;
        if (pop_log.size() < 3) $display("FAIL ro_first_pc: got %0d pops expected >=3", pop_log.size());
        else if (pop_log[0] !== 32'h0040_0100) $display("FAIL ro_first_pc: got %h expected 00400100", pop_log[0]);
        else passed++;
        total++;
        if (acc_log.size() < 1) $display("FAIL ro_first_addr: got no accepts expected >=1");
        else if (acc_log[0] !== 32'h0040_0100) $display("FAIL ro_first_addr: got %h expected 00400100", acc_log[0]);
        else passed++;
    endtask

    task automatic test_redirect_pop_rvalid;
        bit found = 0;
        int n;
        logic [31:0] old_exp;
        do_boot(32'h0040_0000, 1);
        instr_ready = 1'b1;
        tick(6);
        for (int i = 0; i < 20 && !found; i++) begin
            if (instr_valid && imem_rvalid) found = 1;
            else tick(1);
        end
        total++; if (!found) $display("FAIL prv_setup: got no pop+rvalid cycle expected one within 20"); else passed++;
        old_exp = exp_pc;
        n = pop_cnt;
        redirect = 1'b1; redirect_pc = 32'h0040_0200;
        tick(1);
        redirect = 1'b0;
        total++;
        if (pop_cnt != n + 1) $display("FAIL prv_consumed: got %0d pops expected %0d", pop_cnt, n + 1);
        else if (pop_log[pop_log.size()-1] !== old_exp) $display("FAIL prv_consumed: got %h expected %h", pop_log[pop_log.size()-1], old_exp);
        else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL prv_flush: got %b expected 0", instr_valid); else passed++;
        pop_log.delete();
        tick(12);
        total++;
        if (pop_log.size() < 1) $display("FAIL prv_first_pc: got no pops expected >=1");
        else if (pop_log[0] !== 32'h0040_0200) $display("FAIL prv_first_pc: got %h expected 00400200", pop_log[0]);
        else passed++;
    endtask

    task automatic test_misaligned;
        do_boot(32'h0040_0023, 1);
        instr_ready = 1'b1;
        tick(1);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0020) $display("FAIL misalign: got req=%b addr=%h expected 1/00400020", imem_req, imem_addr); else passed++;
        tick(6);
    endtask

    task automatic test_wrap;
        do_boot(32'h0040_0000, 1);
        instr_ready = 1'b1;
        tick(5);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(1);
        redirect = 1'b0;
        acc_log.delete(); pop_log.delete();
        tick(8);
        total++;
        if (acc_log.size() < 2) $display("FAIL wrap_addr: got %0d accepts expected >=2", acc_log.size());
        else if (acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0) $display("FAIL wrap_addr: got %h %h expected fffffffc 00000000", acc_log[0], acc_log[1]);
        else passed++;
        total++;
        if (pop_log.size() < 2) $display("FAIL wrap_pc: got %0d pops expected >=2", pop_log.size());
        else if (pop_log[1] !== 32'h0) $display("FAIL wrap_pc: got %h expected 00000000", pop_log[1]);
        else passed++;
    endtask

    task automatic test_async_reset;
        do_boot(32'h0040_0000, 1);
        instr_ready = 1'b1;
        tick(6);
        total++; if (instr_valid !== 1'b1 || imem_req !== 1'b1) $display("FAIL ar_pre: got valid=%b req=%b expected 1/1", instr_valid, imem_req); else passed++;
        #1 reset = 1'b1;
        #1;
        total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL ar_async: got valid=%b req=%b expected 0/0", instr_valid, imem_req); else passed++;
        total++; if (imem_addr !== 32'h0) $display("FAIL ar_addr: got %h expected 0", imem_addr); else passed++;
        mon_en = 0;
        tick(2);
    endtask

    task automatic test_perf;
`ifdef IFQ_PERF_EN
        do_boot(32'h0040_0000, 1);
        instr_ready = 1'b0;
        #1;
        total++; if (perf_fetched !== 32'h0 || perf_flushed !== 32'h0) $display("FAIL perf_rst: got %0d/%0d expected 0/0", perf_fetched, perf_flushed); else passed++;
        tick(9);
        imem_ready = 1'b0; instr_ready = 1'b1;
        tick(3);
        instr_ready = 1'b0;
        total++; if (perf_fetched !== 32'd3) $display("FAIL perf_pops: got %0d expected 3", perf_fetched); else passed++;
        imem_ready = 1'b1; mem_lat = 1;
        tick(1);
        mem_lat = 8;
        tick(1);
        imem_ready = 1'b0;
        tick(1);
        total++; if (instr_valid !== 1'b1) $display("FAIL perf_setup: got %b expected 1", instr_valid); else passed++;
        redirect = 1'b1; redirect_pc = 32'h0040_0800;
        tick(1);
        redirect = 1'b0;
        tick(10);
        total++; if (perf_fetched !== 32'd3) $display("FAIL perf_fetched: got %0d expected 3", perf_fetched); else passed++;
        total++; if (perf_flushed !== 32'd3) $display("FAIL perf_flushed: got %0d expected 3", perf_flushed); else passed++;
`endif
    endtask

    task automatic test_random;
        int n;
        for (int r = 0; r < 6; r++) begin
            do_boot($urandom, $urandom_range(1, 4));
            rand_ready = 1; rv_gaps = 1;
            tick(1);
            for (int i = 0; i < 150; i++) begin
                instr_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) begin
                    redirect = 1'b1; redirect_pc = $urandom;
                end else begin
                    redirect = 1'b0;
                end
                tick(1);
            end
            redirect = 1'b0; instr_ready = 1'b1;
            n = pop_cnt;
            tick(30);
            total++; if (pop_cnt <= n) $display("FAIL rand_progress: got %0d pops expected > %0d", pop_cnt, n); else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_boot;
        test_backpressure;
        test_redirect_outstanding;
        test_redirect_pop_rvalid;
        test_misaligned;
        test_wrap;
        test_async_reset;
        test_perf;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end directly upstream of the single-cycle processor core.
- Owns the fetch PC and issues in-order word reads to instruction memory.
- Buffers returned words with their PCs in a DEPTH-entry FIFO and presents them to the core on a valid/ready handshake.
- Boots from the same load_pc the core receives. Flushes on core redirect (branch/jump).

Parameters:
- DEPTH, 4, FIFO entries and maximum in-flight reads; power of two, >= 2.
- AW, 32, address/PC width.
- DW, 32, instruction width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- load_pc  in  AW  boot PC, sampled on first clk edge after reset deasserts
- imem_req  out  1  read request valid
- imem_addr  out  AW  word-aligned read address
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid; responses in request order, >= 1 cycle after accept
- imem_rdata  in  DW  read data
- redirect  in  1  core redirect strobe
- redirect_pc  in  AW  redirect target
- instr_valid  out  1  FIFO head valid
- instr  out  DW  FIFO head instruction
- instr_pc  out  AW  FIFO head PC
- instr_ready  in  1  core consumes head

Behaviour:
- Reset (async, active-high) clears all state:
  - state=BOOT; fetch_pc=0, rsp_pc=0, count=0, outstanding=0, discard=0.
  - Outputs: imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0.
- BOOT: first clk edge with reset low sets fetch_pc=rsp_pc={load_pc[AW-1:2],2'b00} and moves to RUN. No request is issued in BOOT.
- RUN request issue:
  - imem_req=1 iff no redirect this cycle and outstanding+count < DEPTH.
  - imem_addr=fetch_pc.
  - Accept = imem_req && imem_ready → fetch_pc += 4 (wraps modulo 2^AW) and outstanding += 1.
  - imem_req/imem_addr hold stable until accepted.
- Response:
  - imem_rvalid always decrements outstanding.
  - If discard>0: word dropped, discard -= 1.
  - Otherwise: push {imem_rdata, rsp_pc} to FIFO and rsp_pc += 4.
  - Credit rule guarantees no push when full; a push into a full FIFO is a design error (assertion).
- Consume:
  - instr_valid = count!=0; instr/instr_pc show the head combinationally from FIFO storage.
  - Pop iff instr_valid && instr_ready.
  - Push and pop in the same cycle keep count unchanged, including at count==DEPTH-1 and at 1.
- Redirect (priority over everything else in RUN):
  - The same-cycle pop completes, since the core owns that instruction.
  - FIFO flushed: count=0, pointers=0.
  - fetch_pc=rsp_pc={redirect_pc[AW-1:2],2'b00}.
  - discard = outstanding − (imem_rvalid?1:0); a same-cycle response is dropped and counted.
  - imem_req=0 in the redirect cycle.
  - Back-to-back redirects: the last one wins; discard is recomputed from the live outstanding.
- Redirect in BOOT: ignored; load_pc still wins.
- Latency: request accept at edge N, rvalid during cycle N+k → instr_valid high from edge N+k+1 (one-cycle FIFO latency, no bypass).
- Reset mid-operation: everything discarded immediately. Late memory responses after reset are the memory's responsibility; the memory is reset on the same signal.
- Counters: count and outstanding are $clog2(DEPTH)+1 bits; discard ≤ DEPTH.

Optional Feature:
- Macro IFQ_PERF_EN.
- Defined: adds ports perf_fetched (out, 32, popped instructions) and perf_flushed (out, 32, FIFO entries plus dropped responses discarded by redirects).
  - Both reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Boot: reset=1 for 10 ns, then load_pc=0x00400020, reset=0, imem_ready=1, 1-cycle memory. Required:
  - First imem_addr=0x00400020.
  - Subsequent addresses 0x00400024, 0x00400028.
  - instr_pc sequence matches, instr matches memory.
- Backpressure: instr_ready=0 with DEPTH=4. Required:
  - Exactly 4 requests accepted, then imem_req=0.
  - Raising instr_ready pops 4 entries in order, then fetching resumes at +0x10.
- Redirect with 2 reads outstanding (3-cycle memory), redirect_pc=0x00400103. Required:
  - FIFO empties next cycle.
  - Both stale responses are dropped.
  - First delivered instr_pc=0x00400100.
  - imem_req=0 in the redirect cycle.
- Redirect same cycle as pop and as rvalid. Required:
  - The popped instruction is counted consumed.
  - The same-cycle rvalid word never appears on instr.
- Misaligned load_pc=0x00400023 at boot. Required: first imem_addr=0x00400020.
- Wrap: redirect_pc=0xFFFFFFFC. Required: addresses 0xFFFFFFFC then 0x00000000.
- Mid-fetch reset assertion. Required: instr_valid and imem_req fall asynchronously, before the next clk edge.
- IFQ_PERF_EN build: 3 pops, then a redirect flushing 2 entries plus 1 outstanding read. Required: perf_fetched=3, perf_flushed=3.
